// File: rtl/subst_pkg.sv
// Shared types and defaults for the character substitution engine.
// Holds the control state encoding and the parameter defaults used by the top.
package subst_pkg;

   localparam int         DEFAULT_TABLE_DEPTH = 16;
   localparam logic [7:0] DEFAULT_PAD_CHAR    = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/subst_engine_if.sv
// Text-in / substituted-text-out stream bundle with valid/ready handshakes.
// The engine uses the slave view; the character source/sink uses the master view.
interface subst_engine_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_char;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;
   logic       out_hit;

   modport slave (
      input  in_valid, in_char, out_ready,
      output in_ready, out_valid, out_char, out_hit
   );

   modport master (
      output in_valid, in_char, out_ready,
      input  in_ready, out_valid, out_char, out_hit
   );

endinterface

// File: rtl/subst_table.sv
// Key/value substitution storage with one write port and a combinational
// lookup that returns the lowest-index live entry matching the key.
module subst_table
   import subst_pkg::*;
#(
   parameter int TABLE_DEPTH = DEFAULT_TABLE_DEPTH
) (
   input  logic                           clk,
   input  logic                           wr_en,
   input  logic [$clog2(TABLE_DEPTH)-1:0] wr_idx,
   input  logic [7:0]                     wr_key,
   input  logic [7:0]                     wr_val,
   input  logic [7:0]                     key,
   input  logic [$clog2(TABLE_DEPTH):0]   count,
   output logic                           hit,
   output logic [7:0]                     value
);

   localparam int CNT_W = $clog2(TABLE_DEPTH) + 1;

   logic [7:0]             key_mem [TABLE_DEPTH];
   logic [7:0]             val_mem [TABLE_DEPTH];
   logic [TABLE_DEPTH-1:0] match;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         key_mem[wr_idx] <= wr_key;
         val_mem[wr_idx] <= wr_val;
      end
   end

   // Entries at or above the live count hold stale data from earlier loads.
   generate
      for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_match
         localparam logic [CNT_W-1:0] ENTRY_IDX = CNT_W'(gi);
         assign match[gi] = (ENTRY_IDX < count) && (key_mem[gi] == key);
      end
   endgenerate

   // Walk from the top down so the lowest matching index is the last writer.
   always_comb begin
      hit   = 1'b0;
      value = 8'h00;
      for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit   = 1'b1;
            value = val_mem[i];
         end
      end
   end

endmodule

// File: rtl/subst_engine.sv
// Character substitution engine: loads key/replacement pairs into a table,
// then streams text through it with a one-cycle registered lookup.
module subst_engine
   import subst_pkg::*;
#(
   parameter int         TABLE_DEPTH = DEFAULT_TABLE_DEPTH,
   parameter logic [7:0] PAD_CHAR    = DEFAULT_PAD_CHAR
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_start,
   input  logic [5:0]     load_len,
   input  logic           pair_valid,
   input  logic [7:0]     pair_lhs,
   input  logic [7:0]     pair_rhs,
   output logic           load_done,
   output logic           load_ovf,
   subst_engine_if.slave  stream
);

   localparam int               IDX_W      = $clog2(TABLE_DEPTH);
   localparam int               CNT_W      = IDX_W + 1;
   localparam logic [CNT_W-1:0] TABLE_FULL = CNT_W'(TABLE_DEPTH);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [5:0]       recv_reg, recv_next;
   logic [5:0]       len_reg, len_next;
   logic [5:0]       recv_inc;
   logic             ovf_reg, ovf_next;
   logic             wr_en;

   logic             out_valid_reg;
   logic [7:0]       out_char_reg;
   logic             out_hit_reg;
   logic             accept;
   logic             table_hit;
   logic [7:0]       table_value;

   subst_table #(
      .TABLE_DEPTH (TABLE_DEPTH)
   ) u_table (
      .clk    (clk),
      .wr_en  (wr_en),
      .wr_idx (count_reg[IDX_W-1:0]),
      .wr_key (pair_lhs),
      .wr_val (pair_rhs),
      .key    (stream.in_char),
      .count  (count_reg),
      .hit    (table_hit),
      .value  (table_value)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         recv_reg  <= '0;
         len_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         recv_reg  <= recv_next;
         len_reg   <= len_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      recv_next  = recv_reg;
      len_next   = len_reg;
      ovf_next   = ovf_reg;
      wr_en      = 1'b0;
      recv_inc   = recv_reg + 6'd1;

      case (state_reg)
         ST_LOAD: begin
            if (pair_valid) begin
               recv_next = recv_inc;
               // Pad pairs only advance the received count.
               if (pair_lhs != PAD_CHAR) begin
                  if (count_reg < TABLE_FULL) begin
                     wr_en      = 1'b1;
                     count_next = count_reg + 1'b1;
                  end else begin
                     ovf_next = 1'b1;
                  end
               end
               if (recv_inc == len_reg) begin
                  state_next = ST_RUN;
               end
            end
         end
         default: begin
         end
      endcase

      // A reload restarts from any state and overrides any pair this cycle.
      if (load_start) begin
         count_next = '0;
         recv_next  = '0;
         len_next   = load_len;
         ovf_next   = 1'b0;
         wr_en      = 1'b0;
         state_next = (load_len == 6'd0) ? ST_RUN : ST_LOAD;
      end
   end

   assign stream.in_ready = (state_reg == ST_RUN) && (!out_valid_reg || stream.out_ready);
   assign accept          = stream.in_valid && stream.in_ready;

   // Output register drains independently of the load state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_char_reg  <= 8'h00;
         out_hit_reg   <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_char_reg  <= table_hit ? table_value : stream.in_char;
         out_hit_reg   <= table_hit;
      end else if (stream.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign stream.out_valid = out_valid_reg;
   assign stream.out_char  = out_char_reg;
   assign stream.out_hit   = out_hit_reg;
   assign load_done        = (state_reg == ST_RUN);
   assign load_ovf         = ovf_reg;

endmodule

// File: tb/tb_subst_engine.sv
// Bench for subst_engine: directed scenarios plus randomized load/stream rounds
// checked against a list-based substitution model and an expected-output queue.
module tb_subst_engine;
   import subst_pkg::*;

   localparam int         DEPTH = 16;
   localparam logic [7:0] PAD   = 8'h20;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_start;
   logic [5:0] load_len;
   logic       pair_valid;
   logic [7:0] pair_lhs;
   logic [7:0] pair_rhs;
   logic       load_done;
   logic       load_ovf;

   subst_engine_if s ();

   subst_engine #(
      .TABLE_DEPTH (DEPTH),
      .PAD_CHAR    (PAD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .pair_valid (pair_valid),
      .pair_lhs   (pair_lhs),
      .pair_rhs   (pair_rhs),
      .load_done  (load_done),
      .load_ovf   (load_ovf),
      .stream     (s.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: ordered list of stored pairs, first match wins.
   logic [7:0] m_key[$];
   logic [7:0] m_val[$];
   bit         m_ovf = 1'b0;
   bit         m_run = 1'b0;

   function automatic logic [8:0] m_lookup(input logic [7:0] c);
      foreach (m_key[i]) begin
         if (m_key[i] == c) return {1'b1, m_val[i]};
      end
      return {1'b0, c};
   endfunction

   function automatic void m_add_pair(input logic [7:0] lhs, input logic [7:0] rhs);
      if (lhs != PAD) begin
         if (m_key.size() < DEPTH) begin
            m_key.push_back(lhs);
            m_val.push_back(rhs);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endfunction

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   logic [7:0] p_lhs[64];
   logic [7:0] p_rhs[64];
   bit         stall_force = 1'b0;
   bit         rand_ready  = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         s.out_ready = stall_force ? 1'b0 : (rand_ready ? (($urandom % 4) != 0) : 1'b1);
      end
   end

   // Compare process: every cycle, away from the clock edge.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_char;
   logic       prev_hit;
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", s.out_valid, 1);
               check("hold_char", s.out_char, prev_char);
               check("hold_hit", s.out_hit, prev_hit);
            end
            if (s.out_valid && s.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output got char 0x%0h expected no output", s.out_char);
               end else begin
                  e = exp_q.pop_front();
                  check("out_char", s.out_char, e[7:0]);
                  check("out_hit", s.out_hit, e[8]);
                  got_q.push_back({s.out_hit, s.out_char});
                  $display("xfer t=%0d out_char=0x%02h hit=%0d", cyc, s.out_char, s.out_hit);
               end
            end
            if (!m_run) check("in_ready_not_run", s.in_ready, 0);
            else        check("in_ready_rule", s.in_ready, (!s.out_valid || s.out_ready));
            if (s.in_valid && s.in_ready) exp_q.push_back(m_lookup(s.in_char));
            prev_stall = s.out_valid && !s.out_ready;
            prev_char  = s.out_char;
            prev_hit   = s.out_hit;
         end
      end
   end

   task automatic start_load(input int len);
      load_start = 1'b1;
      load_len   = 6'(len);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      m_key.delete();
      m_val.delete();
      m_ovf = 1'b0;
      m_run = (len == 0);
   endtask

   task automatic do_load(input int len, input bit gaps);
      start_load(len);
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            repeat ($urandom % 3) begin
               @(negedge clk);
               check("load_done_busy", load_done, 0);
               @(posedge clk);
               #1;
            end
         end
         pair_valid = 1'b1;
         pair_lhs   = p_lhs[i];
         pair_rhs   = p_rhs[i];
         @(negedge clk);
         check("load_done_busy", load_done, 0);
         @(posedge clk);
         #1;
         pair_valid = 1'b0;
         m_add_pair(p_lhs[i], p_rhs[i]);
         if (i == len - 1) m_run = 1'b1;
      end
      @(negedge clk);
      check("load_done_after", load_done, 1);
      check("load_ovf", load_ovf, m_ovf);
      $display("load len=%0d stored=%0d ovf=%0d", len, m_key.size(), m_ovf);
      @(posedge clk);
      #1;
   endtask

   task automatic send_char(input logic [7:0] c);
      int guard = 0;
      s.in_valid = 1'b1;
      s.in_char  = c;
      @(negedge clk);
      while (!s.in_ready && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout got in_ready 0 expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
      s.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         g++;
         @(posedge clk);
         #1;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic send_str(input string str);
      for (int i = 0; i < str.len(); i++) send_char(str[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_load_done"}, load_done, 0);
      check({tag, "_load_ovf"}, load_ovf, 0);
      check({tag, "_in_ready"}, s.in_ready, 0);
      check({tag, "_out_valid"}, s.out_valid, 0);
      check({tag, "_out_char"}, s.out_char, 0);
      check({tag, "_out_hit"}, s.out_hit, 0);
   endtask

   task automatic basic_cat_test(input string tag);
      p_lhs[0] = "a"; p_rhs[0] = "b";
      p_lhs[1] = "c"; p_rhs[1] = "d";
      p_lhs[2] = PAD; p_rhs[2] = PAD;
      do_load(3, 1'b0);
      check({tag, "_model_c"}, m_lookup("c"), {1'b1, 8'h64});
      check({tag, "_model_t"}, m_lookup("t"), {1'b0, 8'h74});
      got_q.delete();
      send_str("cat");
      drain();
      check({tag, "_count"}, got_q.size(), 3);
      check({tag, "_0"}, got_q[0], {1'b1, 8'h64});
      check({tag, "_1"}, got_q[1], {1'b1, 8'h62});
      check({tag, "_2"}, got_q[2], {1'b0, 8'h74});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst = 1'b1;
      load_start = 1'b0;
      load_len = '0;
      pair_valid = 1'b0;
      pair_lhs = '0;
      pair_rhs = '0;
      s.in_valid = 1'b0;
      s.in_char = '0;
      s.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Three pairs including a pad, then "cat".
      basic_cat_test("cat");

      // Empty table: text passes through untouched.
      do_load(0, 1'b0);
      got_q.delete();
      send_str("xyz");
      drain();
      check("xyz_0", got_q[0], {1'b0, 8'h78});
      check("xyz_1", got_q[1], {1'b0, 8'h79});
      check("xyz_2", got_q[2], {1'b0, 8'h7a});

      // Duplicate keys: the first stored one wins.
      p_lhs[0] = "q"; p_rhs[0] = "1";
      p_lhs[1] = "q"; p_rhs[1] = "2";
      do_load(2, 1'b0);
      got_q.delete();
      send_char("q");
      drain();
      check("dup_q", got_q[0], {1'b1, 8'h31});

      // Overflow: 20 distinct keys into a 16-entry table.
      for (int i = 0; i < 20; i++) begin
         p_lhs[i] = 8'(8'h41 + i);
         p_rhs[i] = 8'(8'h61 + i);
      end
      do_load(20, 1'b0);
      check("ovf_literal", load_ovf, 1);
      got_q.delete();
      for (int i = 0; i < 20; i++) send_char(8'(8'h41 + i));
      drain();
      for (int i = 0; i < 20; i++) begin
         if (i < 16) check("ovf_stored", got_q[i], {1'b1, 8'(8'h61 + i)});
         else        check("ovf_dropped", got_q[i], {1'b0, 8'(8'h41 + i)});
      end

      // Backpressure: five stalled cycles, then full-rate streaming.
      p_lhs[0] = "m"; p_rhs[0] = "n";
      do_load(1, 1'b0);
      got_q.delete();
      stall_force = 1'b1;
      send_char("m");
      s.in_valid = 1'b1;
      s.in_char  = "k";
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", s.in_ready, 0);
         check("stall_out_char", s.out_char, 8'h6e);
         check("stall_out_valid", s.out_valid, 1);
         @(posedge clk);
         #1;
      end
      stall_force = 1'b0;
      send_char("k");
      t0 = cyc;
      for (int i = 0; i < 10; i++) send_char(8'(8'h6d - (i % 2)));
      check("stream_rate", cyc - t0, 10);
      drain();
      check("stall_total", got_q.size(), 12);

      // Reload while an output is still pending.
      stall_force = 1'b1;
      send_char("m");
      stall_force = 1'b0;
      rand_ready = 1'b1;
      p_lhs[0] = "m"; p_rhs[0] = "z";
      p_lhs[1] = "k"; p_rhs[1] = "y";
      do_load(2, 1'b1);
      drain();
      send_str("mk");
      drain();
      rand_ready = 1'b0;

      // Reset in the middle of a load.
      start_load(4);
      for (int i = 0; i < 2; i++) begin
         pair_valid = 1'b1;
         pair_lhs = 8'(8'h61 + i);
         pair_rhs = 8'(8'h30 + i);
         @(posedge clk);
         #1;
      end
      pair_valid = 1'b0;
      rst = 1'b1;
      m_run = 1'b0;
      m_key.delete();
      m_val.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midload_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      basic_cat_test("after_rst");

      // Randomized rounds.
      for (int r = 0; r < 8; r++) begin
         int len;
         len = $urandom % 25;
         for (int i = 0; i < len; i++) begin
            p_lhs[i] = (($urandom % 6) == 0) ? PAD : 8'(8'h61 + ($urandom % 8));
            p_rhs[i] = 8'(8'h41 + ($urandom % 26));
         end
         rand_ready = 1'b1;
         do_load(len, 1'b1);
         repeat (2) begin
            pair_valid = 1'b1;
            pair_lhs = 8'(8'h61 + ($urandom % 8));
            pair_rhs = 8'h21;
            @(posedge clk);
            #1;
         end
         pair_valid = 1'b0;
         for (int i = 0; i < 40; i++) begin
            send_char(8'(8'h61 + ($urandom % 10)));
            repeat ($urandom % 2) begin
               @(posedge clk);
               #1;
            end
         end
         drain();
      end
      rand_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
